local_flit_injector: RTL and testbench

LOCAL_FLIT_INJECTOR -- requirements
Module: local_flit_injector

---
 rtl/local_flit_injector_pkg.sv | 10 +
 rtl/pronoc_pkg.sv | 29 ++
 rtl/local_flit_injector_if.sv | 28 ++
 rtl/injector_credit_counter.sv | 28 ++
 rtl/local_flit_injector.sv | 138 +++++++++++++
 tb/tb_local_flit_injector.sv | 282 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/local_flit_injector_pkg.sv
// rtl/local_flit_injector_pkg.sv - injector-local FSM state type
package local_flit_injector_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } inj_state_e;

endpackage

// File: rtl/pronoc_pkg.sv
// rtl/pronoc_pkg.sv - NoC-wide flit channel, flit and header flit types
package pronoc_pkg;

    localparam int NOC_V = 2;
    localparam int EAw   = 4;
    localparam int Fpay  = 32;

    // Flag fields sit at the top of the flit, above vc and payload
    typedef struct packed {
        logic              hdr_flag;
        logic              tail_flag;
        logic [NOC_V-1:0]  vc;
        logic [Fpay-1:0]   payload;
    } flit_t;

    typedef struct packed {
        flit_t             flit;
        logic              flit_wr;
        logic [NOC_V-1:0]  credit;
    } flit_chanel_t;

    // Header flit payload layout: destination on top, source below it
    typedef struct packed {
        logic [EAw-1:0]        dest;
        logic [EAw-1:0]        src;
        logic [Fpay-2*EAw-1:0] rsv;
    } hdr_flit_t;

endpackage

// File: rtl/local_flit_injector_if.sv
// rtl/local_flit_injector_if.sv - packet descriptor and payload handshakes
interface local_flit_injector_if #(
    parameter int V            = pronoc_pkg::NOC_V,
    parameter int MAX_PCK_SIZE = 16
);
    localparam int SW = $clog2(MAX_PCK_SIZE) + 1;

    logic                        pck_valid;
    logic                        pck_ready;
    logic [pronoc_pkg::EAw-1:0]  pck_dest;
    logic [SW-1:0]               pck_size;
    logic [V-1:0]                pck_vc;

    logic                        pld_valid;
    logic                        pld_ready;
    logic [pronoc_pkg::Fpay-1:0] pld_data;

    modport master (
        output pck_valid, pck_dest, pck_size, pck_vc, pld_valid, pld_data,
        input  pck_ready, pld_ready
    );

    modport slave (
        input  pck_valid, pck_dest, pck_size, pck_vc, pld_valid, pld_data,
        output pck_ready, pld_ready
    );

endinterface

// File: rtl/injector_credit_counter.sv
// rtl/injector_credit_counter.sv - saturating per-VC credit counter with sticky error
module injector_credit_counter #(
    parameter int B = 4,
    localparam int CW = $clog2(B) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          err
);

    // Send and return in the same cycle cancel; out-of-range moves saturate and flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= CW'(B);
            err   <= 1'b0;
        end else if (dec && !inc) begin
            if (count == '0) err <= 1'b1;
            else             count <= count - CW'(1);
        end else if (inc && !dec) begin
            if (count == CW'(B)) err <= 1'b1;
            else                 count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/local_flit_injector.sv
// rtl/local_flit_injector.sv - turns packet descriptors and payload words into flits
module local_flit_injector
    import pronoc_pkg::*, local_flit_injector_pkg::*;
#(
    parameter int V            = NOC_V,
    parameter int B            = 4,
    parameter int MAX_PCK_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [EAw-1:0]       current_e_addr,
    local_flit_injector_if.slave inj,
    output flit_chanel_t         chan_out,
    input  logic [V-1:0]         credit_in,
    output logic                 busy,
    output logic                 credit_err
);

    localparam int SW = $clog2(MAX_PCK_SIZE) + 1;
    localparam int CW = $clog2(B) + 1;

    inj_state_e           state, state_next;
    logic                 rst_done;
    logic [EAw-1:0]       dest_q;
    logic [SW-1:0]        size_q;
    logic [V-1:0]         vc_q;
    logic [SW-1:0]        idx_q;
    logic                 pck_rdy, pld_rdy;
    logic                 hdr_wr, body_wr, last;
    logic [V-1:0]         dec_vec, cnt_nz, cnt_err;
    logic [V-1:0][CW-1:0] credit_cnt;
    hdr_flit_t            hdr;

    assign last       = (idx_q == size_q - SW'(1));
    assign dec_vec    = (hdr_wr || body_wr) ? vc_q : '0;
    assign busy       = (state != IDLE);
    assign credit_err = |cnt_err;

    assign inj.pck_ready = pck_rdy;
    assign inj.pld_ready = pld_rdy;

    for (genvar i = 0; i < V; i++) begin : g_cnt
        injector_credit_counter #(.B(B)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .dec   (dec_vec[i]),
            .inc   (credit_in[i]),
            .count (credit_cnt[i]),
            .err   (cnt_err[i])
        );
        assign cnt_nz[i] = (credit_cnt[i] != '0);
    end

    // State register; rst_done keeps pck_ready low until the first edge after release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rst_done <= 1'b0;
        end else begin
            state    <= state_next;
            rst_done <= 1'b1;
        end
    end

    // Next state, handshake readies and flit write strobes
    always_comb begin
        state_next = state;
        pck_rdy    = 1'b0;
        pld_rdy    = 1'b0;
        hdr_wr     = 1'b0;
        body_wr    = 1'b0;
        case (state)
            IDLE: begin
                pck_rdy = rst_done && |(inj.pck_vc & cnt_nz);
                if (inj.pck_valid && pck_rdy) state_next = HDR;
            end
            HDR: begin
                hdr_wr     = 1'b1;
                state_next = (size_q == SW'(1)) ? IDLE : BODY;
            end
            BODY: begin
                pld_rdy = |(vc_q & cnt_nz);
                if (inj.pld_valid && pld_rdy) begin
                    body_wr = 1'b1;
                    if (last) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the descriptor and track the index of the next flit to send
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dest_q <= '0;
            size_q <= SW'(1);
            vc_q   <= '0;
            idx_q  <= '0;
        end else begin
            if (state == IDLE && inj.pck_valid && pck_rdy) begin
                dest_q <= inj.pck_dest;
                size_q <= (inj.pck_size == '0) ? SW'(1) : inj.pck_size;
                vc_q   <= inj.pck_vc;
            end
            if (hdr_wr)       idx_q <= SW'(1);
            else if (body_wr) idx_q <= idx_q + SW'(1);
        end
    end

    // Header payload built from the latched destination and our own address
    always_comb begin
        hdr      = '0;
        hdr.dest = dest_q;
        hdr.src  = current_e_addr;
    end

    // Register flits onto the channel; the flit field holds between writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chan_out <= '0;
        end else begin
            chan_out.flit_wr <= hdr_wr || body_wr;
            chan_out.credit  <= '0;
            if (hdr_wr) begin
                chan_out.flit.hdr_flag  <= 1'b1;
                chan_out.flit.tail_flag <= (size_q == SW'(1));
                chan_out.flit.vc        <= vc_q;
                chan_out.flit.payload   <= hdr;
            end else if (body_wr) begin
                chan_out.flit.hdr_flag  <= 1'b0;
                chan_out.flit.tail_flag <= last;
                chan_out.flit.vc        <= vc_q;
                chan_out.flit.payload   <= inj.pld_data;
            end
        end
    end

endmodule

// File: tb/tb_local_flit_injector.sv
// tb/tb_local_flit_injector.sv - scoreboard bench for local_flit_injector
module tb_local_flit_injector;
    import pronoc_pkg::*;

    localparam logic [3:0] SRC = 4'h3;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   current_e_addr;
    flit_chanel_t chan_out;
    logic [1:0]   credit_in;
    logic         busy;
    logic         credit_err;

    int    n_pass = 0;
    int    n_total = 0;
    flit_t exp_q[$];
    flit_t mon_exp;

    local_flit_injector_if #(.V(2), .MAX_PCK_SIZE(16)) inj ();

    local_flit_injector #(.V(2), .B(4), .MAX_PCK_SIZE(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .current_e_addr (current_e_addr),
        .inj            (inj),
        .chan_out       (chan_out),
        .credit_in      (credit_in),
        .busy           (busy),
        .credit_err     (credit_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic flit_t mk(input bit h, input bit t, input logic [1:0] vc, input logic [31:0] p);
        flit_t f;
        f.hdr_flag  = h;
        f.tail_flag = t;
        f.vc        = vc;
        f.payload   = p;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pck(input logic [3:0] dest, input logic [4:0] size, input logic [1:0] vc);
        int n;
        inj.pck_dest  = dest;
        inj.pck_size  = size;
        inj.pck_vc    = vc;
        inj.pck_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!inj.pck_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!inj.pck_ready) begin
            n_total++;
            $display("FAIL pck_ready_timeout: got 0 expected 1");
        end else begin
            exp_q.push_back(mk(1'b1, (size <= 5'd1), vc, {dest, SRC, 24'h0}));
        end
        @(posedge clk);
        #1;
        inj.pck_valid = 1'b0;
    endtask

    // Scoreboard monitor: every written flit must match the next expected one
    always @(negedge clk) begin
        if (reset && chan_out.flit_wr) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_flit: got %h expected none", chan_out.flit);
            end else begin
                mon_exp = exp_q.pop_front();
                check("flit", 64'(chan_out.flit), 64'(mon_exp));
            end
            check("credit_field", 64'(chan_out.credit), 64'(0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        credit_in      = 2'b00;
        current_e_addr = SRC;
        inj.pck_valid  = 1'b0;
        inj.pck_dest   = 4'h0;
        inj.pck_size   = 5'd1;
        inj.pck_vc     = 2'b01;
        inj.pld_valid  = 1'b0;
        inj.pld_data   = 32'h0;

        // reset state and release timing
        #12;
        check("rst_flit_wr", 64'(chan_out.flit_wr), 64'(0));
        check("rst_flit", 64'(chan_out.flit), 64'(0));
        check("rst_pck_ready", 64'(inj.pck_ready), 64'(0));
        check("rst_pld_ready", 64'(inj.pld_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_credit_err", 64'(credit_err), 64'(0));
        check("rst_cnt0", 64'(dut.credit_cnt[0]), 64'(4));
        check("rst_cnt1", 64'(dut.credit_cnt[1]), 64'(4));
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("pck_ready_at_release", 64'(inj.pck_ready), 64'(0));
        tick();
        check("pck_ready_first_edge", 64'(inj.pck_ready), 64'(1));

        // single-flit packet
        send_pck(4'h5, 5'd1, 2'b01);
        check("single_busy_hdr", 64'(busy), 64'(1));
        check("single_no_flit_yet", 64'(chan_out.flit_wr), 64'(0));
        tick();
        check("single_flit_wr", 64'(chan_out.flit_wr), 64'(1));
        check("single_cnt0", 64'(dut.credit_cnt[0]), 64'(3));
        check("single_busy_done", 64'(busy), 64'(0));
        credit_in = 2'b01;
        tick();
        credit_in = 2'b00;
        check("credit_return_cnt0", 64'(dut.credit_cnt[0]), 64'(4));

        // four-flit packet, payload always valid, no credits back
        inj.pld_valid = 1'b1;
        inj.pld_data  = 32'hA000_0001;
        send_pck(4'h6, 5'd4, 2'b01);
        exp_q.push_back(mk(1'b0, 1'b0, 2'b01, 32'hA000_0001));
        exp_q.push_back(mk(1'b0, 1'b0, 2'b01, 32'hA000_0002));
        exp_q.push_back(mk(1'b0, 1'b1, 2'b01, 32'hA000_0003));
        tick();
        check("p4_hdr_wr", 64'(chan_out.flit_wr), 64'(1));
        tick();
        check("p4_b1_wr", 64'(chan_out.flit_wr), 64'(1));
        inj.pld_data = 32'hA000_0002;
        tick();
        check("p4_b2_wr", 64'(chan_out.flit_wr), 64'(1));
        inj.pld_data = 32'hA000_0003;
        tick();
        check("p4_b3_wr", 64'(chan_out.flit_wr), 64'(1));
        check("p4_cnt0", 64'(dut.credit_cnt[0]), 64'(0));
        check("p4_busy", 64'(busy), 64'(0));
        inj.pld_valid = 1'b0;
        tick();
        check("p4_idle_no_flit", 64'(chan_out.flit_wr), 64'(0));
        check("p4_pld_ready", 64'(inj.pld_ready), 64'(0));
        check("p4_pck_ready_empty", 64'(inj.pck_ready), 64'(0));

        // credit starvation mid-packet
        credit_in = 2'b01;
        tick();
        tick();
        credit_in = 2'b00;
        check("starve_cnt0_pre", 64'(dut.credit_cnt[0]), 64'(2));
        send_pck(4'h7, 5'd4, 2'b01);
        exp_q.push_back(mk(1'b0, 1'b0, 2'b01, 32'hB000_0001));
        exp_q.push_back(mk(1'b0, 1'b0, 2'b01, 32'hB000_0002));
        exp_q.push_back(mk(1'b0, 1'b1, 2'b01, 32'hB000_0003));
        inj.pld_valid = 1'b1;
        inj.pld_data  = 32'hB000_0001;
        tick();
        tick();
        check("starve_b1_wr", 64'(chan_out.flit_wr), 64'(1));
        check("starve_cnt0_empty", 64'(dut.credit_cnt[0]), 64'(0));
        inj.pld_data = 32'hB000_0002;
        repeat (3) begin
            tick();
            check("starve_no_flit", 64'(chan_out.flit_wr), 64'(0));
        end
        check("starve_pld_ready", 64'(inj.pld_ready), 64'(0));
        check("starve_busy", 64'(busy), 64'(1));
        credit_in = 2'b01;
        tick();
        credit_in = 2'b00;
        check("starve_credit_no_flit", 64'(chan_out.flit_wr), 64'(0));
        check("starve_cnt0_one", 64'(dut.credit_cnt[0]), 64'(1));
        check("starve_pld_ready_up", 64'(inj.pld_ready), 64'(1));
        tick();
        check("starve_b2_wr", 64'(chan_out.flit_wr), 64'(1));
        check("starve_cnt0_back0", 64'(dut.credit_cnt[0]), 64'(0));
        inj.pld_data = 32'hB000_0003;
        tick();
        check("starve_single_flit", 64'(chan_out.flit_wr), 64'(0));
        check("starve_pld_ready_down", 64'(inj.pld_ready), 64'(0));
        credit_in = 2'b01;
        tick();
        credit_in = 2'b00;
        tick();
        check("starve_b3_wr", 64'(chan_out.flit_wr), 64'(1));
        check("starve_done_busy", 64'(busy), 64'(0));
        inj.pld_valid = 1'b0;

        // send and credit return on VC1 in the same cycle
        send_pck(4'h9, 5'd1, 2'b10);
        credit_in = 2'b10;
        tick();
        credit_in = 2'b00;
        check("simul_flit_wr", 64'(chan_out.flit_wr), 64'(1));
        check("simul_cnt1", 64'(dut.credit_cnt[1]), 64'(4));
        check("simul_no_err", 64'(credit_err), 64'(0));

        // size 0 behaves as a single-flit packet
        send_pck(4'hA, 5'd0, 2'b10);
        tick();
        check("size0_flit_wr", 64'(chan_out.flit_wr), 64'(1));
        check("size0_busy", 64'(busy), 64'(0));
        check("size0_cnt1", 64'(dut.credit_cnt[1]), 64'(3));
        credit_in = 2'b10;
        tick();
        credit_in = 2'b00;

        // overflow on VC0
        credit_in = 2'b01;
        repeat (4) tick();
        credit_in = 2'b00;
        check("ovf_cnt0_full", 64'(dut.credit_cnt[0]), 64'(4));
        check("ovf_no_err_yet", 64'(credit_err), 64'(0));
        credit_in = 2'b01;
        tick();
        credit_in = 2'b00;
        check("ovf_err", 64'(credit_err), 64'(1));
        check("ovf_cnt0_sat", 64'(dut.credit_cnt[0]), 64'(4));
        repeat (3) tick();
        check("ovf_err_sticky", 64'(credit_err), 64'(1));

        // reset in the middle of a five-flit packet
        inj.pld_valid = 1'b1;
        inj.pld_data  = 32'hC000_0001;
        send_pck(4'hB, 5'd5, 2'b10);
        exp_q.push_back(mk(1'b0, 1'b0, 2'b10, 32'hC000_0001));
        tick();
        tick();
        inj.pld_data = 32'hC000_0002;
        tick();
        check("mid_flit2_wr", 64'(chan_out.flit_wr), 64'(1));
        #1 reset = 1'b0;
        #1;
        check("mid_rst_flit_wr", 64'(chan_out.flit_wr), 64'(0));
        check("mid_rst_flit", 64'(chan_out.flit), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_pld_ready", 64'(inj.pld_ready), 64'(0));
        check("mid_rst_pck_ready", 64'(inj.pck_ready), 64'(0));
        check("mid_rst_err", 64'(credit_err), 64'(0));
        check("mid_rst_cnt0", 64'(dut.credit_cnt[0]), 64'(4));
        check("mid_rst_cnt1", 64'(dut.credit_cnt[1]), 64'(4));
        inj.pld_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        tick();
        check("post_rst_pck_ready", 64'(inj.pck_ready), 64'(1));
        send_pck(4'hC, 5'd2, 2'b01);
        exp_q.push_back(mk(1'b0, 1'b1, 2'b01, 32'hD000_0001));
        inj.pld_valid = 1'b1;
        inj.pld_data  = 32'hD000_0001;
        tick();
        check("post_rst_hdr_wr", 64'(chan_out.flit_wr), 64'(1));
        tick();
        check("post_rst_tail_wr", 64'(chan_out.flit_wr), 64'(1));
        check("post_rst_busy", 64'(busy), 64'(0));
        inj.pld_valid = 1'b0;
        repeat (3) tick();

        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
